// File: rtl/start_debouncer_if.sv
// Key/Busy inputs and Start/Reject/Pressed/StartCount outputs of the pushbutton front end.
`timescale 1ns/100ps
interface start_debouncer_if;
  localparam int unsigned COUNT_W = 8;

  logic               Key;
  logic               Busy;
  logic               Start;
  logic               Reject;
  logic               Pressed;
  logic [COUNT_W-1:0] StartCount;

  modport master (
    output Key,
    output Busy,
    input  Start,
    input  Reject,
    input  Pressed,
    input  StartCount
  );

  modport slave (
    input  Key,
    input  Busy,
    output Start,
    output Reject,
    output Pressed,
    output StartCount
  );
endinterface

// File: rtl/start_debouncer.sv
// Turns the raw active-low pushbutton into a debounced level and a single Start
// (or Reject when the counter is Busy) per press.
`timescale 1ns/100ps
module start_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  start_debouncer_if.slave  bus
);
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned COUNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {IDLE, HELD} state_t;

  logic               s1;
  logic               s2;
  logic               raw;
  logic [CNT_W-1:0]   cnt;
  logic               pressed;
  state_t             state;
  state_t             state_nxt;
  logic               start_nxt;
  logic               reject_nxt;
  logic               start_q;
  logic               reject_q;
  logic [COUNT_W-1:0] count_q;

  // Two-flop synchronizer; idles released (Key high).
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= bus.Key;
      s2 <= s1;
    end
  end

  assign raw = ~s2;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt     <= '0;
      pressed <= 1'b0;
    end else if (raw == pressed) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      pressed <= ~pressed;
      cnt     <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // One-shot: Busy is looked at only when leaving IDLE.
  always_comb begin
    state_nxt  = state;
    start_nxt  = 1'b0;
    reject_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pressed) begin
          state_nxt  = HELD;
          start_nxt  = ~bus.Busy;
          reject_nxt = bus.Busy;
        end
      end
      HELD: begin
        if (!pressed) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      reject_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state    <= state_nxt;
      start_q  <= start_nxt;
      reject_q <= reject_nxt;
      count_q  <= count_q + COUNT_W'(start_nxt);
    end
  end

  assign bus.Start      = start_q;
  assign bus.Reject     = reject_q;
  assign bus.Pressed    = pressed;
  assign bus.StartCount = count_q;
endmodule

// File: tb/tb_start_debouncer.sv
// Directed scenarios plus randomized bouncing key/busy, checked every cycle
// against a window-based behavioural model.
`timescale 1ns/100ps
module tb_start_debouncer;
  localparam int unsigned D = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  start_debouncer_if bus ();

  start_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #1 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: kq[i] is the key sampled i+1 edges ago. The debounced level flips when
  // the D synchronized samples seen by the filter all oppose it; a pulse is issued
  // on the edge after the level rises, Start or Reject chosen by Busy at that edge.
  logic       kq [0:D];
  logic       m_pressed = 1'b0;
  logic       m_prev    = 1'b0;
  logic       m_start   = 1'b0;
  logic       m_reject  = 1'b0;
  logic [7:0] m_cnt     = 8'd0;
  logic       m_flip;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i <= D; i++) kq[i] = 1'b1;
      m_pressed = 1'b0;
      m_prev    = 1'b0;
      m_start   = 1'b0;
      m_reject  = 1'b0;
      m_cnt     = 8'd0;
    end else begin
      m_flip = 1'b1;
      for (int i = 1; i <= D; i++) if (kq[i] != m_pressed) m_flip = 1'b0;
      m_start  = m_pressed && !m_prev && !bus.Busy;
      m_reject = m_pressed && !m_prev && bus.Busy;
      if (m_start) m_cnt = m_cnt + 8'd1;
      m_prev = m_pressed;
      if (m_flip) m_pressed = ~m_pressed;
      for (int i = D; i >= 1; i--) kq[i] = kq[i-1];
      kq[0] = bus.Key;
    end
  end

  always @(posedge Clock) begin
    #0.5;
    chk("model_start",   bus.Start,      m_start);
    chk("model_reject",  bus.Reject,     m_reject);
    chk("model_pressed", bus.Pressed,    m_pressed);
    chk("model_count",   bus.StartCount, m_cnt);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic edge_s();
    @(posedge Clock);
    #0.5;
  endtask

  task automatic reset_pulse();
    @(negedge Clock);
    Reset = 1'b0;
    cyc(2);
    Reset = 1'b1;
    cyc(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    bus.Key  = 1'b1;
    bus.Busy = 1'b0;
    Reset    = 1'b0;
    cyc(3);
    edge_s();
    chk("rst_start",   bus.Start,      1'b0);
    chk("rst_reject",  bus.Reject,     1'b0);
    chk("rst_pressed", bus.Pressed,    1'b0);
    chk("rst_count",   bus.StartCount, 8'd0);
    @(negedge Clock);
    Reset = 1'b1;
    cyc(3);

    // Clean press: Pressed at t0+5, Start at t0+6.
    bus.Key = 1'b0;
    for (int k = 0; k < 8; k++) begin
      edge_s();
      chk("t1_pressed", bus.Pressed, 1'(k >= 5));
      chk("t1_start",   bus.Start,   1'(k == 6));
    end
    chk("t1_count", bus.StartCount, 8'd1);
    cyc(13);
    bus.Key = 1'b1;
    cyc(10);

    // Bounce shorter than D samples.
    for (int r = 0; r < 4; r++) begin
      bus.Key = 1'b0;
      cyc(3);
      bus.Key = 1'b1;
      cyc(1);
    end
    cyc(10);
    chk("t2_pressed", bus.Pressed,    1'b0);
    chk("t2_count",   bus.StartCount, 8'd1);

    // Busy press: Reject at t0+6, no Start even after Busy drops.
    bus.Busy = 1'b1;
    bus.Key  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      edge_s();
      chk("t3_reject", bus.Reject, 1'(k == 6));
      chk("t3_start",  bus.Start,  1'b0);
    end
    @(negedge Clock);
    bus.Busy = 1'b0;
    cyc(5);
    chk("t3_count", bus.StartCount, 8'd1);
    bus.Key = 1'b1;
    cyc(10);

    // Hold and re-press from a fresh reset.
    reset_pulse();
    bus.Key = 1'b0;
    cyc(30);
    chk("t4_count_hold", bus.StartCount, 8'd1);
    bus.Key = 1'b1;
    cyc(10);
    bus.Key = 1'b0;
    cyc(10);
    chk("t4_count", bus.StartCount, 8'd2);
    bus.Key = 1'b1;
    cyc(10);

    // Reset mid-debounce with key held low.
    bus.Key = 1'b0;
    for (int k = 0; k < 4; k++) edge_s();
    @(negedge Clock);
    Reset = 1'b0;
    edge_s();
    chk("t5_rst_pressed", bus.Pressed, 1'b0);
    chk("t5_rst_start",   bus.Start,   1'b0);
    @(negedge Clock);
    Reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      edge_s();
      chk("t5_pressed", bus.Pressed, 1'(k >= 5));
      chk("t5_start",   bus.Start,   1'(k == 6));
    end
    chk("t5_count", bus.StartCount, 8'd1);
    @(negedge Clock);
    bus.Key = 1'b1;
    cyc(10);

    // Reset asserted during a Start pulse drops it immediately.
    bus.Key = 1'b0;
    repeat (7) @(posedge Clock);
    #0.2;
    chk("t5b_start_before", bus.Start, 1'b1);
    #0.1;
    Reset = 1'b0;
    #0.1;
    chk("t5b_start_after", bus.Start, 1'b0);
    chk("t5b_count_after", bus.StartCount, 8'd0);
    cyc(2);
    Reset = 1'b1;
    bus.Key = 1'b1;
    cyc(10);

    // Wrap after 256 accepted presses.
    reset_pulse();
    for (int i = 0; i < 256; i++) begin
      bus.Key = 1'b0;
      cyc(8);
      bus.Key = 1'b1;
      cyc(8);
    end
    chk("t6_wrap", bus.StartCount, 8'd0);
    bus.Key = 1'b0;
    cyc(8);
    bus.Key = 1'b1;
    cyc(8);
    chk("t6_wrap_plus1", bus.StartCount, 8'd1);

    // Random bouncing key, random Busy, occasional async reset.
    for (int c = 0; c < 3000; c += run) begin
      run = int'($urandom_range(1, 8));
      bus.Key = ($urandom_range(0, 3) != 0) ? ~bus.Key : bus.Key;
      for (int j = 0; j < run; j++) begin
        if ($urandom_range(0, 5) == 0) bus.Busy = ~bus.Busy;
        Reset = ($urandom_range(0, 499) != 0);
        cyc(1);
      end
    end
    Reset = 1'b1;
    bus.Key = 1'b1;
    cyc(15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
